uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 21 ++
 rtl/uart_tx_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Word-push handshake into the UART transmit FIFO.
// The producer drives data/valid; the FIFO answers with ready.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] i_data;
  logic                 i_valid;
  logic                 o_ready;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word FIFO in front of it.
// Frames: start, LSB-first data, optional parity, 1 or 2 stops.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 104,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_tx_fifo_if.slave tx,
  output logic          o_line,
  output logic          o_busy,
  output logic [AW:0]   o_level
);

  localparam logic [15:0] RELOAD    = 16'(CLK_DIV - 1);
  localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [AW:0] DEPTH_L   = (AW + 1)'(FIFO_DEPTH);
  localparam logic        ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  state_e state_q, state_d;

  logic [15:0]          baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 line_q, line_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic [AW:0]          lvl_q, lvl_d;

  logic                 push;
  logic                 pop;
  logic                 load;
  logic                 empty;
  logic                 tick;
  logic [DATA_BITS-1:0] head;

  assign tx.o_ready = (lvl_q != DEPTH_L);
  assign push       = tx.i_valid && tx.o_ready && !i_rst;
  assign empty      = (lvl_q == '0);
  assign tick       = (baud_q == '0);
  assign head       = mem_q[rd_q];

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    line_d  = line_q;
    load    = 1'b0;
    if (state_q != IDLE) begin
      baud_d = tick ? RELOAD : baud_q - 16'd1;
    end
    unique case (state_q)
      IDLE: begin
        load = !empty;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
          line_d  = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              line_d  = par_q;
            end else begin
              state_d = STOP;
              line_d  = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            line_d  = shift_q[1];
          end
        end
      end
      PAR: begin
        if (tick) begin
          state_d = STOP;
          line_d  = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              line_d  = 1'b1;
              baud_d  = '0;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
        baud_d  = '0;
      end
    endcase
    // Back-to-back frames reuse the same load path as a start from idle.
    if (load) begin
      state_d = START;
      baud_d  = RELOAD;
      bit_d   = '0;
      shift_d = head;
      par_d   = (^head) ^ ODD;
      line_d  = 1'b0;
    end
  end

  assign pop = load;

  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    lvl_d = lvl_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      line_q  <= line_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_q] <= tx.i_data;
    end
  end

  assign o_line  = line_q;
  assign o_busy  = (state_q != IDLE);
  assign o_level = lvl_q;

endmodule
